// File: rtl/open_drain_bus_arbiter.sv
// Round-robin arbiter that serialises the winning requester's word MSB-first onto a wired-AND open-drain bus.
// Optional collision abort is compiled in when ODB_COLLISION_CHECK_EN is defined.
module open_drain_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic                      bus_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      bus_drive_low,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CYC_W = $clog2(BIT_CYCLES);
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, SEND, STOP} state_t;

    state_t             state, state_nx;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nx;
    logic [CYC_W-1:0]   cyc, cyc_nx;
    logic [BIT_W-1:0]   bit_idx, bit_idx_nx;
    logic [DATA_W-1:0]  word, word_nx;
    logic [NUM_REQ-1:0] grant_q, grant_nx;
    logic               aborted, aborted_nx;
    logic               found;
    int                 winner;
    logic               last_cyc;
    logic               collision;

    assign last_cyc = (cyc == CYC_W'(BIT_CYCLES - 1));

    // Scan requests starting at rr_ptr so the agent after the last winner gets first chance.
    always_comb begin
        found  = 1'b0;
        winner = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                found  = 1'b1;
                winner = (int'(rr_ptr) + i) % NUM_REQ;
            end
        end
    end

`ifdef ODB_COLLISION_CHECK_EN
    // A released (1) bit that reads back low means another agent is holding the bus.
    assign collision = (state == SEND) && last_cyc && word[bit_idx] && !bus_in;
`else
    logic bus_in_unused;
    assign bus_in_unused = bus_in;
    assign collision     = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        rr_ptr_nx  = rr_ptr;
        cyc_nx     = cyc;
        bit_idx_nx = bit_idx;
        word_nx    = word;
        grant_nx   = grant_q;
        aborted_nx = aborted;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx         = SEND;
                    grant_nx         = '0;
                    grant_nx[winner] = 1'b1;
                    word_nx          = data_in[winner*DATA_W +: DATA_W];
                    bit_idx_nx       = BIT_W'(DATA_W - 1);
                    cyc_nx           = '0;
                    aborted_nx       = 1'b0;
                    rr_ptr_nx        = PTR_W'((winner + 1) % NUM_REQ);
                end
            end
            SEND: begin
                if (collision) begin
                    state_nx   = STOP;
                    cyc_nx     = '0;
                    aborted_nx = 1'b1;
                end else if (last_cyc) begin
                    cyc_nx = '0;
                    if (bit_idx == '0) begin
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx - 1'b1;
                    end
                end else begin
                    cyc_nx = cyc + 1'b1;
                end
            end
            STOP: begin
                if (last_cyc) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    cyc_nx   = '0;
                end else begin
                    cyc_nx = cyc + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            cyc     <= '0;
            bit_idx <= '0;
            word    <= '0;
            grant_q <= '0;
            aborted <= 1'b0;
        end else begin
            state   <= state_nx;
            rr_ptr  <= rr_ptr_nx;
            cyc     <= cyc_nx;
            bit_idx <= bit_idx_nx;
            word    <= word_nx;
            grant_q <= grant_nx;
            aborted <= aborted_nx;
        end
    end

    // Outputs decode from state so a reset releases the bus on the very next cycle.
    assign grant         = grant_q;
    assign busy          = (state != IDLE);
    assign bus_drive_low = (state == SEND) && !word[bit_idx];
    assign done          = (state == STOP) && last_cyc;
    assign err           = done && aborted;

endmodule

// File: tb/tb_open_drain_bus_arbiter.sv
// Self-checking bench for open_drain_bus_arbiter: transaction-level reference model plus directed literal checks.
module tb_open_drain_bus_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BC = 4;
    localparam int SEND_LEN = DW * BC;
    localparam int XFER_LEN = SEND_LEN + BC;
`ifdef ODB_COLLISION_CHECK_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [NR*DW-1:0] data_in = '0;
    logic           bus_in;
    logic           bus_force_low = 1'b0;
    logic [NR-1:0]  grant;
    logic           bus_drive_low;
    logic           busy;
    logic           done;
    logic           err;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Transaction-level model: owner, latched word and position within the transfer.
    bit          m_busy  = 1'b0;
    int          m_t     = 0;
    int          m_owner = 0;
    int          m_rr    = 0;
    bit          m_abort = 1'b0;
    logic [DW-1:0] m_word = '0;
    bit          m_found;
    int          m_win;

    assign bus_in = bus_force_low ? 1'b0 : ~bus_drive_low;

    always #5 clk = ~clk;

    open_drain_bus_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BIT_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .bus_in(bus_in),
        .grant(grant), .bus_drive_low(bus_drive_low), .busy(busy), .done(done), .err(err)
    );

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*DW-1:0] d,
                                 input logic rs, input logic fl);
        req           = r;
        data_in       = d;
        rst           = rs;
        bus_force_low = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Waits (bounded) for the current transfer to finish and the next one to start, then checks its owner.
    task automatic waitNewGrant(input logic [NR-1:0] exp, input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
        while (busy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checkOutput({nm, "_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({nm, "_grant"}, {28'd0, grant}, {28'd0, exp});
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_rr    = 0;
            m_t     = 0;
            m_abort = 1'b0;
        end else if (!m_busy) begin
            m_found = 1'b0;
            m_win   = 0;
            for (int i = 0; i < NR; i++) begin
                if (!m_found && req[(m_rr + i) % NR]) begin
                    m_found = 1'b1;
                    m_win   = (m_rr + i) % NR;
                end
            end
            if (m_found) begin
                m_busy  = 1'b1;
                m_owner = m_win;
                m_word  = data_in[m_win*DW +: DW];
                m_t     = 0;
                m_abort = 1'b0;
                m_rr    = (m_win + 1) % NR;
            end
        end else begin
            if (COLL && m_t < SEND_LEN && (m_t % BC) == BC - 1
                && m_word[DW-1-m_t/BC] && bus_force_low) begin
                m_abort = 1'b1;
                m_t     = SEND_LEN;
            end else if (m_t == XFER_LEN - 1) begin
                m_busy = 1'b0;
            end else begin
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] e_grant;
        logic e_drive, e_done;
        if (check_en) begin
            e_grant = '0;
            if (m_busy) e_grant[m_owner] = 1'b1;
            e_drive = m_busy && m_t < SEND_LEN && !m_word[DW-1-m_t/BC];
            e_done  = m_busy && m_t == XFER_LEN - 1;
            checkOutput("model_grant", {28'd0, grant}, {28'd0, e_grant});
            checkOutput("model_busy", {31'd0, busy}, {31'd0, m_busy});
            checkOutput("model_drive", {31'd0, bus_drive_low}, {31'd0, e_drive});
            checkOutput("model_done", {31'd0, done}, {31'd0, e_done});
            checkOutput("model_err", {31'd0, err}, {31'd0, e_done && m_abort});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_seen;
        logic [7:0] pat;

        applyStimulus('0, '0, 1'b1, 1'b0);
        tick();
        check_en = 1'b1;
        tick();
        rst = 1'b0;

        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checkOutput("idle_grant", {28'd0, grant}, 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_drive", {31'd0, bus_drive_low}, 32'd0);
        checkOutput("idle_done_count", done_seen, 32'd0);

        // Single transfer of 8'hA5 from agent 0; bus_drive_low is the inverted word.
        tick();
        applyStimulus(4'b0001, 32'h000000A5, 1'b0, 1'b0);
        tick();
        req = '0;
        pat = 8'b0101_1010;
        for (int k = 0; k < XFER_LEN; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput("a5_grant", {28'd0, grant}, 32'h1);
            if (k < SEND_LEN)
                checkOutput("a5_drive", {31'd0, bus_drive_low}, {31'd0, pat[7 - k/BC]});
            checkOutput("a5_done", {31'd0, done}, (k == XFER_LEN - 1) ? 32'd1 : 32'd0);
        end
        checkOutput("a5_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        checkOutput("a5_release", {27'd0, busy, grant}, 32'd0);

        // Round-robin order from a fresh pointer.
        applyStimulus('0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0101, 32'h44332211, 1'b0, 1'b0);
        waitNewGrant(4'b0001, "rr_first");
        waitNewGrant(4'b0100, "rr_second");
        req = 4'b0011;
        waitNewGrant(4'b0001, "rr_wrap0");
        waitNewGrant(4'b0010, "rr_wrap1");
        req = '0;

        // Reset in the middle of bit 3, then agent 3 alone.
        req = 4'b0010;
        waitNewGrant(4'b0010, "rst_pre");
        req = '0;
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_outputs", {24'd0, grant, bus_drive_low, busy, done, err}, 32'd0);
        rst = 1'b0;
        req = 4'b1000;
        waitNewGrant(4'b1000, "rst_agent3");
        req = '0;

        // Collision during bit 5 of an all-ones word from agent 2.
        req     = 4'b0100;
        data_in = 32'h00FF0000;
        waitNewGrant(4'b0100, "coll_grant");
        req = '0;
        repeat (8) @(negedge clk);
        bus_force_low = 1'b1;
        repeat (4) @(negedge clk);
        bus_force_low = 1'b0;
        checkOutput("coll_drive", {31'd0, bus_drive_low}, 32'd0);
        repeat (3) @(negedge clk);
`ifdef ODB_COLLISION_CHECK_EN
        checkOutput("coll_done", {31'd0, done}, 32'd1);
        checkOutput("coll_err", {31'd0, err}, 32'd1);
`else
        checkOutput("coll_done_early", {31'd0, done}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("coll_done", {31'd0, done}, 32'd1);
        checkOutput("coll_err", {31'd0, err}, 32'd0);
`endif

        // Randomised traffic: changing req/data mid-transfer, spurious bus pulls, rare resets.
        tick();
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom),
                          $urandom,
                          ($urandom_range(0, 149) == 0),
                          ($urandom_range(0, 7) == 0));
            tick();
        end
        applyStimulus('0, '0, 1'b0, 1'b0);
        repeat (XFER_LEN + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
